fetch_unit: RTL

Instruction fetch stage of the 5-stage RISC-V pipeline; it sits directly upstream of the IF/ID `pipeline_reg` and produces that register's `in` payload. It owns the PC and issues in-order requests to a variable-latency instruction memory using a req/gnt/rvalid handshake. Returned words are buffered in a small queue and presented as `{if_pc, if_instr}` with `if_valid`. Redirects from EX and stalls from the hazard unit are absorbed here, including dropping responses that were in flight when a redirect occurred.

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the IF/ID pipeline register.
// Owns the PC, issues in-order requests over a req/gnt/rvalid handshake to a
// variable-latency instruction memory, buffers returned words in a small
// queue and presents the head as {if_pc, if_instr} with if_valid.
// Redirects from EX discard queued words and any responses still in flight.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   imem_req/imem_addr    fetch request and its address (== fetch_pc)
//   imem_gnt              request accepted when imem_req is also high
//   imem_rvalid/rdata     in-order response, >= 1 cycle after its grant
//   stall                 hold the queue head (IF/ID not written)
//   redirect/redirect_pc  taken branch/jump; new target, bits [1:0] ignored
//   if_valid/if_pc/if_instr  queue head; pc/instr are zero when not valid
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] addr_fifo [DEPTH];
  logic [PW-1:0]   af_wr, af_rd;
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [PW-1:0]   q_wr, q_rd;
  logic [CW-1:0]   qcount, inflight, drop_cnt;

  logic            grant, resp, drop, push, pop;
  logic [CW:0]     credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit covers both in-flight requests and queued words, so every
  // accepted response is guaranteed a queue slot.
  always_comb begin
    credit_used = {1'b0, inflight} + {1'b0, qcount};
    imem_req    = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
    grant       = imem_req && imem_gnt;
    resp        = imem_rvalid && (inflight != '0);
    // A response in the redirect cycle belongs to the old path.
    drop        = redirect || (drop_cnt != '0);
    push        = resp && !drop;
    pop         = (qcount != '0) && !stall && !redirect;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      af_wr    <= '0;
      af_rd    <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
      qcount   <= '0;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      if (grant) af_wr <= ptr_inc(af_wr);
      if (resp)  af_rd <= ptr_inc(af_rd);
      case ({grant, resp})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      if (redirect) begin
        fetch_pc <= redirect_pc & ~XLEN'(3);
        q_wr     <= '0;
        q_rd     <= '0;
        qcount   <= '0;
        // Everything still outstanding after this edge is on the old path.
        drop_cnt <= inflight - CW'(resp);
      end else begin
        if (grant) fetch_pc <= fetch_pc + XLEN'(4);
        if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (push) q_wr <= ptr_inc(q_wr);
        if (pop)  q_rd <= ptr_inc(q_rd);
        case ({push, pop})
          2'b10:   qcount <= qcount + 1'b1;
          2'b01:   qcount <= qcount - 1'b1;
          default: qcount <= qcount;
        endcase
      end
    end
  end

  // Payload storage needs no reset: validity is tracked by the counters.
  always_ff @(posedge clk) begin
    if (grant) addr_fifo[af_wr] <= fetch_pc;
    if (push) begin
      q_pc[q_wr]    <= addr_fifo[af_rd];
      q_instr[q_wr] <= imem_rdata;
    end
  end

  assign imem_addr = fetch_pc;
  assign if_valid  = (qcount != '0);
  assign if_pc     = if_valid ? q_pc[q_rd]    : '0;
  assign if_instr  = if_valid ? q_instr[q_rd] : '0;

endmodule
